// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, opcode legality
// check and the arbiter FSM state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLTU = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Opcodes are allocated contiguously from 0, so ALU_SRA is the last legal one.
    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= ALU_SRA;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the requester that was not granted last wins.
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    assign gnt0 = valid0 && (!valid1 || last_grant);
    assign gnt1 = valid1 && (!valid0 || !last_grant);

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters with round-robin
// arbitration, registered ALU inputs and per-requester valid/ready responses.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_zero,
    output logic             resp0_err,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_zero,
    output logic             resp1_err,
    output logic [OPW-1:0]   alu_op,
    output logic [WIDTH-1:0] alu_ina,
    output logic [WIDTH-1:0] alu_inb,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    arb_state_t state;
    arb_state_t state_next;
    logic       last_grant;
    logic       owner;
    logic       gnt0;
    logic       gnt1;
    logic       owner_taken;

    rr_arb2 u_arb (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (last_grant),
        .gnt0       (gnt0),
        .gnt1       (gnt1)
    );

    assign owner_taken = owner ? resp1_ready : resp0_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req0_ready || req1_ready) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (owner_taken) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Readies are held low while reset is asserted so no transfer can complete then.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (state == IDLE && !rst) begin
            req0_ready = gnt0;
            req1_ready = gnt1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            alu_op       <= '0;
            alu_ina      <= '0;
            alu_inb      <= '0;
            resp0_valid  <= 1'b0;
            resp0_result <= '0;
            resp0_zero   <= 1'b0;
            resp0_err    <= 1'b0;
            resp1_valid  <= 1'b0;
            resp1_result <= '0;
            resp1_zero   <= 1'b0;
            resp1_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        alu_op     <= req0_op;
                        alu_ina    <= req0_a;
                        alu_inb    <= req0_b;
                        owner      <= 1'b0;
                        last_grant <= 1'b0;
                    end else if (req1_ready) begin
                        alu_op     <= req1_op;
                        alu_ina    <= req1_a;
                        alu_inb    <= req1_b;
                        owner      <= 1'b1;
                        last_grant <= 1'b1;
                    end
                end
                EXEC: begin
                    // Illegal opcodes report a forced zero result rather than whatever the ALU produced.
                    if (owner) begin
                        resp1_valid  <= 1'b1;
                        resp1_result <= op_is_legal(alu_op) ? alu_out : '0;
                        resp1_zero   <= op_is_legal(alu_op) ? alu_zero : 1'b1;
                        resp1_err    <= !op_is_legal(alu_op);
                    end else begin
                        resp0_valid  <= 1'b1;
                        resp0_result <= op_is_legal(alu_op) ? alu_out : '0;
                        resp0_zero   <= op_is_legal(alu_op) ? alu_zero : 1'b1;
                        resp0_err    <= !op_is_legal(alu_op);
                    end
                end
                RESP: begin
                    if (owner && resp1_ready) begin
                        resp1_valid <= 1'b0;
                    end
                    if (!owner && resp0_ready) begin
                        resp0_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp0_valid, resp0_ready, resp0_zero, resp0_err;
    logic        resp1_valid, resp1_ready, resp1_zero, resp1_err;
    logic [31:0] resp0_result, resp1_result;
    logic [3:0]  alu_op;
    logic [31:0] alu_ina, alu_inb, alu_out;
    logic        alu_zero;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: free/busy, cycles left until the response shows, and the expected response
    bit          m_free = 1'b1;
    int          m_wait = 0;
    int          m_owner = 0;
    int          m_last = 1;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b, m_res;
    logic        m_zero, m_err;

    alu_arbiter #(.WIDTH(32), .OPW(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_result(resp0_result),
        .resp0_zero(resp0_zero), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_result(resp1_result),
        .resp1_zero(resp1_zero), .resp1_err(resp1_err),
        .alu_op(alu_op), .alu_ina(alu_ina), .alu_inb(alu_inb),
        .alu_out(alu_out), .alu_zero(alu_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd3:    return a ^ b;
            4'd4:    return a << b[4:0];
            4'd5:    return a >> b[4:0];
            4'd6:    return a - b;
            4'd7:    return (a < b) ? 32'd1 : 32'd0;
            4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return $unsigned($signed(a) >>> b[4:0]);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // External ALU stand-in; illegal opcodes yield garbage the arbiter must ignore.
    always_comb begin
        alu_out  = alu_ref(alu_op, alu_ina, alu_inb);
        alu_zero = (alu_op <= 4'd9) ? (alu_out == 32'd0) : 1'b0;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        if (observed !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, then advance the model across the edge.
    task automatic applyStimulus(input logic r,
                                 input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                 input logic rr0, input logic rr1);
        logic e0, e1, ev0, ev1;
        @(posedge clk);
        #1;
        rst = r;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        resp0_ready = rr0; resp1_ready = rr1;
        @(negedge clk);
        e0 = !r && m_free && v0 && (!v1 || m_last == 1);
        e1 = !r && m_free && v1 && (!v0 || m_last == 0);
        checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, e0});
        checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, e1});
        ev0 = !m_free && m_wait == 0 && m_owner == 0;
        ev1 = !m_free && m_wait == 0 && m_owner == 1;
        checkOutput("resp0_valid", {31'd0, resp0_valid}, {31'd0, ev0});
        checkOutput("resp1_valid", {31'd0, resp1_valid}, {31'd0, ev1});
        if (ev0) begin
            checkOutput("resp0_result", resp0_result, m_res);
            checkOutput("resp0_zero", {31'd0, resp0_zero}, {31'd0, m_zero});
            checkOutput("resp0_err", {31'd0, resp0_err}, {31'd0, m_err});
        end
        if (ev1) begin
            checkOutput("resp1_result", resp1_result, m_res);
            checkOutput("resp1_zero", {31'd0, resp1_zero}, {31'd0, m_zero});
            checkOutput("resp1_err", {31'd0, resp1_err}, {31'd0, m_err});
        end
        if (!m_free && m_wait == 1) begin
            checkOutput("alu_op", {28'd0, alu_op}, {28'd0, m_op});
            checkOutput("alu_ina", alu_ina, m_a);
            checkOutput("alu_inb", alu_inb, m_b);
        end
        if (r) begin
            m_free = 1'b1;
            m_last = 1;
        end else if (e0 || e1) begin
            m_free  = 1'b0;
            m_wait  = 1;
            m_owner = e0 ? 0 : 1;
            m_last  = m_owner;
            m_op    = e0 ? op0 : op1;
            m_a     = e0 ? a0 : a1;
            m_b     = e0 ? b0 : b1;
            if (m_op <= 4'd9) begin
                m_res  = alu_ref(m_op, m_a, m_b);
                m_zero = (m_res == 32'd0);
                m_err  = 1'b0;
            end else begin
                m_res  = 32'd0;
                m_zero = 1'b1;
                m_err  = 1'b1;
            end
        end else if (!m_free) begin
            if (m_wait > 0) m_wait--;
            else if ((m_owner == 0 && rr0) || (m_owner == 1 && rr1)) m_free = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n, input logic rr0, input logic rr1);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, rr0, rr1);
    endtask

    initial begin
        int grants[$];
        logic [31:0] held;
        rst = 1'b1;
        req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
        repeat (2) @(posedge clk);

        // reset values
        applyStimulus(1'b1, 1'b1, 4'd2, 32'd1, 32'd1, 1'b1, 4'd2, 32'd1, 32'd1, 1'b0, 1'b0);
        checkOutput("rst_alu_op", {28'd0, alu_op}, 32'd0);
        checkOutput("rst_alu_ina", alu_ina, 32'd0);
        checkOutput("rst_resp0_result", resp0_result, 32'd0);
        checkOutput("rst_resp1_err", {31'd0, resp1_err}, 32'd0);

        // ADD 5+7 from requester 0
        applyStimulus(1'b0, 1'b1, 4'b0010, 32'd5, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("add_ready0", {31'd0, req0_ready}, 32'd1);
        idle_cycles(2, 1'b0, 1'b0);
        checkOutput("add_valid0", {31'd0, resp0_valid}, 32'd1);
        checkOutput("add_result", resp0_result, 32'd12);
        checkOutput("add_zero", {31'd0, resp0_zero}, 32'd0);
        idle_cycles(1, 1'b1, 1'b0);

        // strict alternation from reset with both requesters always valid
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b0, 1'b1, 4'b0110, 32'd9, 32'd9, 1'b1, 4'b0000, $urandom, $urandom, 1'b1, 1'b1);
            if (req0_ready) grants.push_back(0);
            if (req1_ready) grants.push_back(1);
            if (resp0_valid) begin
                checkOutput("sub_result", resp0_result, 32'd0);
                checkOutput("sub_zero", {31'd0, resp0_zero}, 32'd1);
            end
        end
        checkOutput("alt_count", grants.size(), 32'd6);
        for (int i = 0; i < grants.size() && i < 6; i++)
            checkOutput($sformatf("alt_grant%0d", i), grants[i], i % 2);
        idle_cycles(1, 1'b1, 1'b1);

        // illegal opcode from requester 1
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'b1100, 32'd3, 32'd4, 1'b0, 1'b0);
        idle_cycles(2, 1'b0, 1'b0);
        checkOutput("ill_result", resp1_result, 32'd0);
        checkOutput("ill_zero", {31'd0, resp1_zero}, 32'd1);
        checkOutput("ill_err", {31'd0, resp1_err}, 32'd1);
        idle_cycles(1, 1'b0, 1'b1);

        // backpressure on response 0 while requester 1 waits
        applyStimulus(1'b0, 1'b1, 4'b0011, 32'hF0F0, 32'h0FF0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        idle_cycles(2, 1'b0, 1'b0);
        held = resp0_result;
        checkOutput("bp_result", held, 32'hFF00);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd2, 32'd1, 32'd2, 1'b0, 1'b0);
            checkOutput("bp_ready1", {31'd0, req1_ready}, 32'd0);
            checkOutput("bp_hold", resp0_result, held);
        end
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd2, 32'd1, 32'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd2, 32'd1, 32'd2, 1'b0, 1'b0);
        checkOutput("bp_accept1", {31'd0, req1_ready}, 32'd1);
        idle_cycles(3, 1'b0, 1'b1);

        // reset while requester 0's op is in EXEC
        applyStimulus(1'b0, 1'b1, 4'd2, 32'd8, 32'd8, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd1, 32'd1, 32'd2, 1'b1, 4'd1, 32'd4, 32'd8, 1'b1, 1'b1);
        checkOutput("rst_exec_valid0", {31'd0, resp0_valid}, 32'd0);
        checkOutput("rst_exec_grant0", {31'd0, req0_ready}, 32'd1);
        idle_cycles(3, 1'b1, 1'b1);

        // a one-cycle valid pulse during RESP is never accepted
        applyStimulus(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 1'b1, 4'd2, 32'd2, 32'd2, 1'b0, 1'b0);
        idle_cycles(2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd2, 32'd6, 32'd6, 1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        checkOutput("pulse_ready0", {31'd0, req0_ready}, 32'd0);
        idle_cycles(1, 1'b0, 1'b1);
        idle_cycles(4, 1'b1, 1'b1);
        checkOutput("pulse_no_resp0", {31'd0, resp0_valid}, 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [3:0]  o0, o1;
            logic [31:0] x0, y0, x1, y1;
            o0 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            o1 = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            x0 = $urandom; x1 = $urandom;
            y0 = ($urandom_range(0, 3) == 0) ? x0 : $urandom;
            y1 = ($urandom_range(0, 3) == 0) ? x1 : $urandom;
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 2) != 0, o0, x0, y0,
                          $urandom_range(0, 2) != 0, o1, x1, y1,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
